// File: rtl/input_conditioner.sv
// Conditions raw board pins: 2-FF synchronizers for buttons and switches, per-button
// debounce with registered press/release pulses, and a registered any-switch-changed pulse.
module input_conditioner #(
    parameter int NUM_BTN = 5,
    parameter int NUM_SW  = 24,
    parameter int CNT_MAX = 2_000_000,
    parameter int CNT_W   = 21
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [NUM_SW-1:0]  sw_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_SW-1:0]  sw_sync,
    output logic               sw_changed
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [NUM_BTN-1:0] btn_s1_q, btn_s2_q;
    logic [NUM_SW-1:0]  sw_s1_q, sw_s2_q, sw_prev_q;
    logic [CNT_W-1:0]   cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] level_q, level_d;
    logic [NUM_BTN-1:0] level_dly_q;
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [NUM_BTN-1:0] release_q, release_d;
    logic               changed_q, changed_d;

    // A button is PENDING while its counter is non-zero; any agreement with the
    // current level drops it back to STABLE, so short glitches never accumulate.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (btn_s2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]   = '0;
                level_d[i] = btn_s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        press_d   = level_q & ~level_dly_q;
        release_d = ~level_q & level_dly_q;
        changed_d = |(sw_s2_q ^ sw_prev_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            btn_s1_q    <= '0;
            btn_s2_q    <= '0;
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            sw_prev_q   <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
            press_q     <= '0;
            release_q   <= '0;
            changed_q   <= 1'b0;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            btn_s1_q    <= btn_raw;
            btn_s2_q    <= btn_s1_q;
            sw_s1_q     <= sw_raw;
            sw_s2_q     <= sw_s1_q;
            sw_prev_q   <= sw_s2_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= press_d;
            release_q   <= release_d;
            changed_q   <= changed_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign sw_sync     = sw_s2_q;
    assign sw_changed  = changed_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios with literal expectations plus a
// randomized phase, all outputs compared every cycle against a behavioural model.
module tb_input_conditioner;

    localparam int NUM_BTN = 5;
    localparam int NUM_SW  = 24;
    localparam int CNT_MAX = 4;
    localparam int CNT_W   = 3;

    logic               clock;
    logic               reset;
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_SW-1:0]  sw_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [NUM_SW-1:0]  sw_sync;
    logic               sw_changed;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    input_conditioner #(
        .NUM_BTN(NUM_BTN),
        .NUM_SW (NUM_SW),
        .CNT_MAX(CNT_MAX),
        .CNT_W  (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .sw_raw     (sw_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .sw_sync    (sw_sync),
        .sw_changed (sw_changed)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Behavioural model: raw values pass through a two-stage delay; a button level
    // flips once its last CNT_MAX synchronized samples (since the last flip/reset)
    // all disagree with it; pulses mark a level change seen one cycle earlier.
    bit [NUM_BTN-1:0] m_s1, m_s2, m_level, m_level_prev, m_press, m_release;
    bit [NUM_SW-1:0]  m_sw1, m_sw2, m_sw_prev;
    bit               m_changed;
    bit               hist [NUM_BTN][CNT_MAX];
    int               hist_n [NUM_BTN];

    always @(posedge clock) begin
        bit [NUM_BTN-1:0] new_level;
        bit               all_diff;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; m_level_prev = '0;
            m_press = '0; m_release = '0;
            m_sw1 = '0; m_sw2 = '0; m_sw_prev = '0; m_changed = 1'b0;
            for (int b = 0; b < NUM_BTN; b++) hist_n[b] = 0;
        end else begin
            new_level = m_level;
            for (int b = 0; b < NUM_BTN; b++) begin
                for (int j = CNT_MAX - 1; j > 0; j--) hist[b][j] = hist[b][j-1];
                hist[b][0] = m_s2[b];
                if (hist_n[b] < CNT_MAX) hist_n[b]++;
                all_diff = (hist_n[b] == CNT_MAX);
                for (int j = 0; j < CNT_MAX; j++)
                    if (hist[b][j] == m_level[b]) all_diff = 1'b0;
                if (all_diff) begin
                    new_level[b] = m_s2[b];
                    hist_n[b]    = 0;
                end
            end
            m_press      = m_level & ~m_level_prev;
            m_release    = ~m_level & m_level_prev;
            m_level_prev = m_level;
            m_level      = new_level;
            m_s2         = m_s1;
            m_s1         = btn_raw;
            m_changed    = (m_sw2 != m_sw_prev);
            m_sw_prev    = m_sw2;
            m_sw2        = m_sw1;
            m_sw1        = sw_raw;
        end
    end

    // Scoreboard compare, every cycle once the model has been reset
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("model btn_level", 32'(btn_level), 32'(m_level));
            chk("model btn_press", 32'(btn_press), 32'(m_press));
            chk("model btn_release", 32'(btn_release), 32'(m_release));
            chk("model sw_sync", 32'(sw_sync), 32'(m_sw2));
            chk("model sw_changed", 32'(sw_changed), 32'(m_changed));
            checks++;
            if ((btn_press & btn_release) != '0) begin
                errors++;
                $display("FAIL press_and_release: press %0h release %0h", btn_press, btn_release);
            end
        end
    end

    initial begin
        int presses;
        int hold;
        reset   = 1'b1;
        btn_raw = 5'b11111;
        sw_raw  = 24'hFFFFFF;

        // Reset holds all outputs low
        for (int i = 0; i < 3; i++) begin
            tick(1);
            cmp_en = 1'b1;
            chk("reset btn_level", 32'(btn_level), 32'h0);
            chk("reset btn_press", 32'(btn_press), 32'h0);
            chk("reset btn_release", 32'(btn_release), 32'h0);
            chk("reset sw_sync", 32'(sw_sync), 32'h0);
            chk("reset sw_changed", 32'(sw_changed), 32'h0);
        end
        btn_raw = '0;
        sw_raw  = '0;
        reset   = 1'b0;
        tick(4);

        // Clean press and release on button 3
        btn_raw[3] = 1'b1;
        tick(5);
        chk("press level3 @5", 32'(btn_level[3]), 32'h0);
        tick(1);
        chk("press level3 @6", 32'(btn_level[3]), 32'h1);
        chk("press pulse3 @6", 32'(btn_press[3]), 32'h0);
        tick(1);
        chk("press pulse3 @7", 32'(btn_press[3]), 32'h1);
        tick(1);
        chk("press pulse3 @8", 32'(btn_press[3]), 32'h0);
        tick(12);
        btn_raw[3] = 1'b0;
        tick(5);
        chk("release level3 @5", 32'(btn_level[3]), 32'h1);
        tick(1);
        chk("release level3 @6", 32'(btn_level[3]), 32'h0);
        tick(1);
        chk("release pulse3 @7", 32'(btn_release[3]), 32'h1);
        chk("release nopress3 @7", 32'(btn_press[3]), 32'h0);
        tick(1);
        chk("release pulse3 @8", 32'(btn_release[3]), 32'h0);
        tick(4);

        // Bouncing button 0
        for (int k = 0; k < 2; k++) begin
            btn_raw[0] = 1'b1;
            tick(2);
            chk("bounce level0 hi", 32'(btn_level[0]), 32'h0);
            btn_raw[0] = 1'b0;
            tick(2);
            chk("bounce level0 lo", 32'(btn_level[0]), 32'h0);
        end
        btn_raw[0] = 1'b1;
        presses = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            if (i == 5) chk("bounce level0 @5", 32'(btn_level[0]), 32'h0);
            if (i == 6) chk("bounce level0 @6", 32'(btn_level[0]), 32'h1);
            presses += int'(btn_press[0]);
        end
        chk("bounce press count", 32'(presses), 32'h1);

        // Simultaneous presses on buttons 1 and 4
        btn_raw[1] = 1'b1;
        btn_raw[4] = 1'b1;
        tick(6);
        chk("simul level", 32'(btn_level), 32'h13);
        tick(1);
        chk("simul press", 32'(btn_press), 32'h12);
        btn_raw = '0;
        tick(10);

        // Reset mid-count on button 2
        btn_raw[2] = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(1);
        chk("midreset level", 32'(btn_level), 32'h0);
        reset = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            chk("midreset level2", 32'(btn_level[2]), (i == 6) ? 32'h1 : 32'h0);
        end
        btn_raw = '0;
        tick(10);

        // Switch change detect
        sw_raw = 24'h200003;
        tick(1);
        chk("sw_sync @1", 32'(sw_sync), 32'h0);
        tick(1);
        chk("sw_sync @2", 32'(sw_sync), 32'h200003);
        chk("sw_changed @2", 32'(sw_changed), 32'h0);
        tick(1);
        chk("sw_changed @3", 32'(sw_changed), 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("sw_changed quiet", 32'(sw_changed), 32'h0);
        end

        // Randomized phase, checked by the model
        for (int seg = 0; seg < 300; seg++) begin
            btn_raw = NUM_BTN'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) sw_raw = NUM_SW'($urandom);
            reset = ($urandom_range(0, 39) == 0);
            hold  = $urandom_range(1, 10);
            tick(1);
            reset = 1'b0;
            tick(hold);
        end

        tick(2);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
